// File: rtl/nanci_pkg.sv
// Shared message and state definitions for the PE network and the result collector.
package nanci_pkg;

    // Default message field widths; modules may override through their own parameters.
    localparam int MSG_ADDR_W = 3;
    localparam int MSG_DATA_W = 3;
    localparam int MSG_W      = MSG_ADDR_W + MSG_DATA_W;

    // Collector FSM encoding: bit 0 = collecting, bit 1 = done, so status outputs
    // come straight off flops.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_COLLECT = 2'b01;
    localparam logic [1:0] ST_DONE    = 2'b10;

    // Address field sits above the data field in a message.
    function automatic logic [31:0] msg_addr(input logic [31:0] msg, input int data_w);
        return msg >> data_w;
    endfunction

    function automatic logic [31:0] msg_data(input logic [31:0] msg, input int data_w);
        return msg & ((32'd1 << data_w) - 32'd1);
    endfunction

endpackage

// File: rtl/pe_result_mem.sv
// Result storage: N entries, one write port, one registered read port,
// per-entry valid bits with single-cycle bulk clear.
module pe_result_mem #(
    parameter int N          = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wvalid_o,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rhit_o
);

    localparam logic [ADDR_WIDTH:0] N_L = (ADDR_WIDTH+1)'(N);

    logic [DATA_WIDTH-1:0] mem_q [N];
    logic [N-1:0]          valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rhit_q;
    logic                  w_in_range;
    logic                  r_in_range;

    assign w_in_range = {1'b0, waddr_i} < N_L;
    assign r_in_range = {1'b0, raddr_i} < N_L;

    // Combinational lookup so the collector can classify the current sample.
    always_comb begin
        wvalid_o = 1'b0;
        if (w_in_range) wvalid_o = valid_q[waddr_i];
    end

    // Data array carries no reset; stale entries are masked by their valid bits.
    always_ff @(posedge clk) begin
        if (we_i && w_in_range) mem_q[waddr_i] <= wdata_i;
    end

    // Valid bits: cleared on reset or at the start of every window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (we_i && w_in_range) begin
            valid_q[waddr_i] <= 1'b1;
        end
    end

    // Registered readout; a write on the same edge is not bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rhit_q  <= 1'b0;
        end else if (r_in_range) begin
            rdata_q <= mem_q[raddr_i];
            rhit_q  <= valid_q[raddr_i];
        end else begin
            rdata_q <= '0;
            rhit_q  <= 1'b0;
        end
    end

    assign rdata_o = rdata_q;
    assign rhit_o  = rhit_q;

endmodule

// File: rtl/pe_result_collector.sv
// Collects {addr,data} messages from a PE chain into a result table during a
// bounded window and reports completion, timeout and duplicate addresses.
//
//   state   | meaning
//   IDLE    | waiting for i_start after reset
//   COLLECT | sampling i_PE every cycle, window counter running
//   DONE    | results and flags frozen until the next i_start
module pe_result_collector
    import nanci_pkg::*;
#(
    parameter int N             = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 3,
    parameter int WINDOW_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
    input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    output logic                           o_rd_hit,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_timeout,
    output logic                           o_dup_err,
    output logic [ADDR_WIDTH:0]            o_count
);

    localparam int                  CW       = $clog2(WINDOW_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0] N_L      = (ADDR_WIDTH+1)'(N);
    localparam logic [CW-1:0]       LAST_CYC = CW'(WINDOW_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;
    logic [CW-1:0]         cyc_q,   cyc_d;
    logic                  to_q,    to_d;
    logic                  dup_q,   dup_d;

    logic [ADDR_WIDTH-1:0] msg_a;
    logic [DATA_WIDTH-1:0] msg_d;
    logic                  in_range;
    logic                  slot_full;
    logic                  we;
    logic                  clr;

    assign msg_a    = ADDR_WIDTH'(msg_addr(32'(i_PE), DATA_WIDTH));
    assign msg_d    = DATA_WIDTH'(msg_data(32'(i_PE), DATA_WIDTH));
    assign in_range = {1'b0, msg_a} < N_L;

    pe_result_mem #(
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr),
        .we_i     (we),
        .waddr_i  (msg_a),
        .wdata_i  (msg_d),
        .wvalid_o (slot_full),
        .raddr_i  (i_rd_addr),
        .rdata_o  (o_rd_data),
        .rhit_o   (o_rd_hit)
    );

    // Next-state: window open/close, fill counting, duplicate and timeout flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        dup_d   = dup_q;
        we      = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                we    = in_range;
                cyc_d = cyc_q + 1'b1;
                if (in_range) begin
                    if (slot_full) dup_d = 1'b1;
                    else           cnt_d = cnt_q + 1'b1;
                end
                // Filling the last entry wins over an expiring window.
                if (cnt_d == N_L) begin
                    state_d = ST_DONE;
                end else if (cyc_q == LAST_CYC) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                    cyc_d   = '0;
                    to_d    = 1'b0;
                    dup_d   = 1'b0;
                    clr     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
            dup_q   <= dup_d;
        end
    end

    assign o_busy    = state_q[0];
    assign o_done    = state_q[1];
    assign o_timeout = to_q;
    assign o_dup_err = dup_q;
    assign o_count   = cnt_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: one N=8 and one N=6 instance share all inputs
// and are compared every cycle against a table-level reference model.
module tb_pe_result_collector;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] pe;
    logic [2:0] rd_addr;

    logic [2:0] rdd8, rdd6;
    logic       rdh8, rdh6, busy8, busy6, done8, done6, to8, to6, dup8, dup6;
    logic [3:0] cnt8, cnt6;

    int checks = 0;
    int errors = 0;

    // Reference model, one slot per instance (0: N=8, 1: N=6).
    bit m_valid [2][8];
    int m_data  [2][8];
    int m_cnt [2], m_dup [2], m_to [2], m_phase [2], m_win [2];
    int e_hit [2], e_data [2], e_dknown [2];

    always #5 clk = ~clk;

    pe_result_collector #(.N(8), .ADDR_WIDTH(3), .DATA_WIDTH(3), .WINDOW_CYCLES(W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_PE(pe), .i_rd_addr(rd_addr),
        .o_rd_data(rdd8), .o_rd_hit(rdh8), .o_busy(busy8), .o_done(done8),
        .o_timeout(to8), .o_dup_err(dup8), .o_count(cnt8));

    pe_result_collector #(.N(6), .ADDR_WIDTH(3), .DATA_WIDTH(3), .WINDOW_CYCLES(W)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_PE(pe), .i_rd_addr(rd_addr),
        .o_rd_data(rdd6), .o_rd_hit(rdh6), .o_busy(busy6), .o_done(done6),
        .o_timeout(to6), .o_dup_err(dup6), .o_count(cnt6));

    function automatic int nk(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) m_valid[k][a] = 0;
            m_cnt[k] = 0; m_dup[k] = 0; m_to[k] = 0; m_phase[k] = 0; m_win[k] = 0;
            e_hit[k] = 0; e_data[k] = 0; e_dknown[k] = 1;
        end
    endtask

    // One rising edge of the model: readout sees the table as it was before the edge.
    task automatic model_edge();
        int a, d, ra, n;
        a  = int'(pe) / 8;
        d  = int'(pe) % 8;
        ra = int'(rd_addr);
        for (int k = 0; k < 2; k++) begin
            n = nk(k);
            if (ra < n) begin
                e_hit[k]    = m_valid[k][ra];
                e_data[k]   = m_data[k][ra];
                e_dknown[k] = m_valid[k][ra];
            end else begin
                e_hit[k] = 0; e_data[k] = 0; e_dknown[k] = 1;
            end
            if (m_phase[k] != 1) begin
                if (start) begin
                    for (int i = 0; i < 8; i++) m_valid[k][i] = 0;
                    m_cnt[k] = 0; m_dup[k] = 0; m_to[k] = 0; m_win[k] = 0;
                    m_phase[k] = 1;
                end
            end else begin
                if (a < n) begin
                    if (m_valid[k][a]) m_dup[k] = 1;
                    else begin m_valid[k][a] = 1; m_cnt[k]++; end
                    m_data[k][a] = d;
                end
                m_win[k]++;
                if (m_cnt[k] == n)      begin m_phase[k] = 2; m_to[k] = 0; end
                else if (m_win[k] == W) begin m_phase[k] = 2; m_to[k] = 1; end
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] ob, od, ot, odp, oc, oh, odat;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin ob = busy8; od = done8; ot = to8; odp = dup8; oc = cnt8; oh = rdh8; odat = rdd8; end
            else        begin ob = busy6; od = done6; ot = to6; odp = dup6; oc = cnt6; oh = rdh6; odat = rdd6; end
            chk($sformatf("n%0d_busy", nk(k)),    ob,  32'(m_phase[k] == 1));
            chk($sformatf("n%0d_done", nk(k)),    od,  32'(m_phase[k] == 2));
            chk($sformatf("n%0d_timeout", nk(k)), ot,  32'(m_to[k]));
            chk($sformatf("n%0d_dup", nk(k)),     odp, 32'(m_dup[k]));
            chk($sformatf("n%0d_count", nk(k)),   oc,  32'(m_cnt[k]));
            chk($sformatf("n%0d_rd_hit", nk(k)),  oh,  32'(e_hit[k]));
            if (e_dknown[k] != 0)
                chk($sformatf("n%0d_rd_data", nk(k)), odat, 32'(e_data[k]));
        end
    endtask

    // Inputs are set before calling; they are held across the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input int a, input int d);
        pe = 6'(a * 8 + d);
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pe = '0; rd_addr = '0;
        model_reset();
        #3 check_all();
        chk("reset_rd_data", 32'(rdd8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full fill in order: addr i carries 7-i.
        pulse_start();
        for (int i = 0; i < 8; i++) send(i, 7 - i);
        chk("full_done", 32'(done8), 32'd1);
        chk("full_count", 32'(cnt8), 32'd8);
        chk("full_timeout", 32'(to8), 32'd0);
        rd_addr = 3'd3;
        pe = '0;
        step();
        chk("full_rd3_data", 32'(rdd8), 32'd4);
        chk("full_rd3_hit", 32'(rdh8), 32'd1);
        for (int i = 0; i < 8; i++) begin rd_addr = 3'(i); step(); end

        // Partial fill followed by repeats of addr 0 until the window expires.
        pulse_start();
        for (int i = 0; i < 5; i++) send(i, i + 1);
        for (int i = 5; i < W - 1; i++) send(0, 0);
        chk("part_busy_last", 32'(busy8), 32'd1);
        send(0, 0);
        chk("part_done", 32'(done8), 32'd1);
        chk("part_timeout", 32'(to8), 32'd1);
        chk("part_dup", 32'(dup8), 32'd1);
        chk("part_count", 32'(cnt8), 32'd5);
        rd_addr = 3'd6;
        step();
        chk("part_rd6_hit", 32'(rdh8), 32'd0);

        // Out-of-range address on the N=6 instance is ignored silently.
        pulse_start();
        send(0, 1);
        for (int i = 0; i < 3; i++) begin pe = 6'b111010; step(); end
        chk("oor_count6", 32'(cnt6), 32'd1);
        chk("oor_dup6", 32'(dup6), 32'd0);
        async_reset();

        // Last distinct entry arrives on the final window cycle.
        pulse_start();
        for (int i = 0; i < 7; i++) send(i, i);
        for (int i = 7; i < W - 1; i++) send(0, 5);
        send(7, 2);
        chk("last_done", 32'(done8), 32'd1);
        chk("last_timeout", 32'(to8), 32'd0);
        chk("last_count", 32'(cnt8), 32'd8);

        // Restart from DONE.
        pe = 6'b111111;
        pulse_start();
        chk("restart_done", 32'(done8), 32'd0);
        chk("restart_busy", 32'(busy8), 32'd1);
        chk("restart_count", 32'(cnt8), 32'd0);
        chk("restart_dup", 32'(dup8), 32'd0);

        // Reset in the middle of a window after three writes.
        async_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send(i, 6);
        async_reset();
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_count", 32'(cnt8), 32'd0);
        for (int i = 0; i < 8; i++) begin rd_addr = 3'(i); step(); end
        pulse_start();
        for (int i = 0; i < 8; i++) send(7 - i, i);
        chk("midrst_recollect", 32'(cnt8), 32'd8);

        // Random traffic with sporadic starts and readouts.
        for (int c = 0; c < 600; c++) begin
            start   = ($urandom_range(0, 9) == 0);
            pe      = 6'($urandom_range(0, 63));
            rd_addr = 3'($urandom_range(0, 7));
            step();
            if (c == 300) async_reset();
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_result_collector.md
PE_RESULT_COLLECTOR -- requirements
Module: pe_result_collector

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of result entries expected (N <= 2**ADDR_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning width of message address field.
REQ-003 SHALL have parameter DATA_WIDTH, default 3, meaning width of message data field.
REQ-004 SHALL have parameter WINDOW_CYCLES, default 16, meaning maximum collect cycles before timeout.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_start  input  1  pulse opening a collect window.
REQ-008 SHALL have port i_PE  input  ADDR_WIDTH+DATA_WIDTH  message from upstream PE o_PE, {addr, data}, addr in upper bits.
REQ-009 SHALL have port i_rd_addr  input  ADDR_WIDTH  readout index.
REQ-010 SHALL have port o_rd_data  output  DATA_WIDTH  stored data at i_rd_addr, registered.
REQ-011 SHALL have port o_rd_hit  output  1  entry at i_rd_addr written this window, registered.
REQ-012 SHALL have port o_busy  output  1  high in COLLECT.
REQ-013 SHALL have port o_done  output  1  high in DONE.
REQ-014 SHALL have port o_timeout  output  1  window expired before N entries filled; valid in DONE.
REQ-015 SHALL have port o_dup_err  output  1  sticky; an already-filled address was received again this window.
REQ-016 SHALL have port o_count  output  ADDR_WIDTH+1  number of distinct entries filled.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-018 IDLE: i_start=1 -> COLLECT next cycle; clear valid bits, o_count, o_timeout, o_dup_err, cycle counter on same edge.
REQ-019 COLLECT: sample i_PE every cycle, starting the first cycle after the i_start edge.
REQ-020 Sample with addr < N and valid[addr]=0 -> write data, set valid[addr], o_count += 1.
REQ-021 Sample with addr < N and valid[addr]=1 -> overwrite data, set o_dup_err, o_count unchanged.
REQ-022 Sample with addr >= N -> ignored, no flag.
REQ-023 Cycle counter increments each COLLECT cycle; counter reaching WINDOW_CYCLES-1 with o_count+write < N -> DONE with o_timeout=1.
REQ-024 Write making o_count reach N -> DONE next cycle, o_timeout=0; takes precedence over a simultaneous window expiry.
REQ-025 i_start in COLLECT ignored.
REQ-026 i_start in DONE behaves as in IDLE: clears state, enters COLLECT.
REQ-027 DONE holds all results and flags until i_start or reset.
REQ-028 Readout: o_rd_data/o_rd_hit reflect i_rd_addr one cycle later, in any state; a same-cycle write is not bypassed (old value returned).
REQ-029 i_rd_addr >= N -> o_rd_data=0, o_rd_hit=0.
REQ-030 o_busy, o_done SHALL be decoded directly from state registers (glitch-free).

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, all valid bits 0, o_count=0, o_timeout=0, o_dup_err=0, o_rd_data=0, o_rd_hit=0, o_busy=0, o_done=0.
REQ-032 Reset asserted mid-COLLECT SHALL discard partial results; data array contents need no reset, valid bits do.
REQ-033 First i_start honoured SHALL be on the first rising edge after rst_n deassertion.

Structure
REQ-034 Message field widths, field-slice helpers and FSM state encodings SHALL live in shared package nanci_pkg, shared with PE.
REQ-035 Storage SHALL be one sub-module pe_result_mem (N x DATA_WIDTH, 1 write port, 1 registered read port, per-entry valid bits with bulk clear).
REQ-036 The FSM, counters and flags SHALL be in pe_result_collector.

Verification
REQ-037 Reset, then i_start, drive addr 0..7 data 7-addr on consecutive cycles -> o_done after 8 samples, o_count=8, o_timeout=0, readout addr 3 = 3'b100 with hit=1.
REQ-038 i_start, drive only addrs 0..4, then hold 6'b000000 repeating addr 0 -> after WINDOW_CYCLES o_done=1, o_timeout=1, o_dup_err=1, o_count=5, readout addr 6 hit=0.
REQ-039 N=6, drive 6'b111010 (addr 7) -> ignored: o_count unchanged, o_dup_err=0.
REQ-040 Eighth distinct write lands on the last window cycle -> o_timeout=0, o_count=8.
REQ-041 Assert rst_n=0 mid-COLLECT after 3 writes -> immediately IDLE, o_count=0, all hits 0; new i_start collects normally.
REQ-042 In DONE, pulse i_start -> o_done=0, o_busy=1 next cycle, o_count=0, o_dup_err=0.
